// File: rtl/sum_prod_pkg.sv
// Shared types and helpers for the sequential sum-of-products engine.
// Optional macro SUM_PROD_MUL_REG_EN adds a product register and a DRAIN state.
package sum_prod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Wide enough for P full-scale products without overflow.
  function automatic int res_width(input int n, input int p);
    return 2 * n + $clog2(p);
  endfunction

endpackage

// File: rtl/sum_prod_mac_if.sv
// Operand/result handshake bundle for sum_prod_mac.
// Width of the result follows sum_prod_pkg::res_width.
interface sum_prod_mac_if #(
  parameter int N = 4,
  parameter int P = 3
);
  localparam int RW = sum_prod_pkg::res_width(N, P);

  logic                    in_valid;
  logic                    in_ready;
  logic [2*P-1:0][N-1:0]   x_in;
  logic                    accum;
  logic                    out_valid;
  logic                    out_ready;
  logic [RW-1:0]           result;
  logic                    busy;

  modport master (
    output in_valid, x_in, accum, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, x_in, accum, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/sum_prod_mul.sv
// N x N -> 2N unsigned multiplier; valid travels with the product.
// With SUM_PROD_MUL_REG_EN defined the product and its valid are registered.
module sum_prod_mul #(
  parameter int N = 4
) (
`ifdef SUM_PROD_MUL_REG_EN
  input  logic             clk,
  input  logic             rst_n,
`endif
  input  logic [N-1:0]     i_a,
  input  logic [N-1:0]     i_b,
  input  logic             i_vld_p0,
  output logic [2*N-1:0]   o_prod,
  output logic             o_vld
);
  localparam int PW = 2 * N;

  logic [PW-1:0] w_prod_p0;

  assign w_prod_p0 = PW'(i_a) * PW'(i_b);

`ifdef SUM_PROD_MUL_REG_EN
  logic [PW-1:0] r_prod_p1;
  logic          r_vld_p1;

  // ---- stage p0 -> p1 ----
  always_ff @(posedge clk) begin
    r_prod_p1 <= w_prod_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p1 <= 1'b0;
    else        r_vld_p1 <= i_vld_p0;
  end

  assign o_prod = r_prod_p1;
  assign o_vld  = r_vld_p1;
`else
  assign o_prod = w_prod_p0;
  assign o_vld  = i_vld_p0;
`endif

endmodule

// File: rtl/sum_prod_mac.sv
// Sequential sum-of-products: result = sum x[2i]*x[2i+1], one pair per cycle.
// Macro SUM_PROD_MUL_REG_EN registers the product and inserts a DRAIN cycle.
module sum_prod_mac
  import sum_prod_pkg::*;
#(
  parameter int N = 4,
  parameter int P = 3
) (
  input logic          clk,
  input logic          rst_n,
  sum_prod_mac_if.slave io_bus
);
  localparam int RW = res_width(N, P);
  localparam int IW = (P > 1) ? $clog2(P) : 1;

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_idx;
  logic [2*P-1:0][N-1:0] r_x;
  logic [RW-1:0]         r_acc;
  logic [RW-1:0]         r_result;
  logic [RW-1:0]         w_sum;
  logic [IW:0]           w_ia, w_ib;
  logic [N-1:0]          w_a, w_b;
  logic [2*N-1:0]        w_prod;
  logic                  w_vld_p0, w_prod_vld;
  logic                  w_accept, w_last, w_fin;

  assign w_accept = (r_state == IDLE) && io_bus.in_valid;
  assign w_last   = (r_idx == IW'(P - 1));
  assign w_vld_p0 = (r_state == CALC);
  assign w_ia     = {r_idx, 1'b0};
  assign w_ib     = {r_idx, 1'b1};
  assign w_a      = r_x[w_ia];
  assign w_b      = r_x[w_ib];

  sum_prod_mul #(.N(N)) u_mul (
`ifdef SUM_PROD_MUL_REG_EN
    .clk      (clk),
    .rst_n    (rst_n),
`endif
    .i_a      (w_a),
    .i_b      (w_b),
    .i_vld_p0 (w_vld_p0),
    .o_prod   (w_prod),
    .o_vld    (w_prod_vld)
  );

  assign w_sum = r_acc + (w_prod_vld ? RW'(w_prod) : '0);

`ifdef SUM_PROD_MUL_REG_EN
  assign w_fin = (r_state == DRAIN);
`else
  assign w_fin = (r_state == CALC) && w_last;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_state_nxt = CALC;
`ifdef SUM_PROD_MUL_REG_EN
      CALC:  if (w_last) w_state_nxt = DRAIN;
`else
      CALC:  if (w_last) w_state_nxt = DONE;
`endif
      DRAIN: w_state_nxt = DONE;
      DONE:  if (io_bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)               r_idx <= '0;
      else if (r_state == CALC)   r_idx <= r_idx + 1'b1;
      if (w_fin)                  r_result <= w_sum;
    end
  end

  // Operands are captured only on accept, so later changes on x_in are invisible.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x   <= io_bus.x_in;
      r_acc <= io_bus.accum ? r_result : '0;
    end else if (r_state == CALC || r_state == DRAIN) begin
      r_acc <= w_sum;
    end
  end

  assign io_bus.in_ready  = (r_state == IDLE);
  assign io_bus.out_valid = (r_state == DONE);
  assign io_bus.busy      = (r_state != IDLE);
  assign io_bus.result    = r_result;

endmodule

// File: tb/tb_sum_prod_mac.sv
// Directed bench for sum_prod_mac (N=4, P=3); honours SUM_PROD_MUL_REG_EN for latency.
module tb_sum_prod_mac;
  localparam int N = 4;
  localparam int P = 3;
`ifdef SUM_PROD_MUL_REG_EN
  localparam int LAT = P + 1;
`else
  localparam int LAT = P;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  sum_prod_mac_if #(.N(N), .P(P)) bus ();

  sum_prod_mac #(.N(N), .P(P)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*P-1:0][N-1:0] mk(input int a0, a1, a2, a3, a4, a5);
    logic [2*P-1:0][N-1:0] v;
    v[0] = N'(a0); v[1] = N'(a1); v[2] = N'(a2);
    v[3] = N'(a3); v[4] = N'(a4); v[5] = N'(a5);
    return v;
  endfunction

  task automatic start_op(input string tag, input logic [2*P-1:0][N-1:0] v, input logic acc);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.x_in     = v;
    bus.accum    = acc;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency/result, optionally holds, then consumes.
  task automatic finish_op(input string tag, input int exp_res, input int hold, input bit scramble);
    int cnt;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin
      if (scramble) bus.x_in = mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                                  $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, "_latency"}, 32'(cnt), 32'(LAT));
    check({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = (h == 2);
      bus.x_in     = mk(15, 15, 15, 15, 15, 15);
      bus.accum    = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_result"}, 32'(bus.result), 32'(exp_res));
      check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_result_kept"}, 32'(bus.result), 32'(exp_res));
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.accum     = 1'b0;
    bus.x_in      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2*3 + 1*4 + 0*5 = 10
    start_op("t1", mk(2, 3, 1, 4, 0, 5), 1'b0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_calc_in_ready", 32'(bus.in_ready), 32'd0);
    finish_op("t1", 10, 0, 1'b0);

    // 56 + 6 + 1 = 63; then 3*225 = 675
    start_op("t2a", mk(7, 8, 2, 3, 1, 1), 1'b0);
    finish_op("t2a", 63, 0, 1'b0);
    start_op("t2b", mk(15, 15, 15, 15, 15, 15), 1'b0);
    finish_op("t2b", 675, 0, 1'b0);

    // 675 + 675 = 1350 mod 1024 = 326; then 326 + 10 = 336
    start_op("t3a", mk(15, 15, 15, 15, 15, 15), 1'b1);
    finish_op("t3a", 326, 0, 1'b0);
    start_op("t3b", mk(2, 3, 1, 4, 0, 5), 1'b1);
    finish_op("t3b", 336, 0, 1'b0);

    // Back-pressure for 5 cycles with an in_valid pulse that must be ignored
    start_op("t4", mk(2, 3, 1, 4, 0, 5), 1'b0);
    finish_op("t4", 10, 5, 1'b0);
    @(posedge clk);
    #1;
    check("t4_no_spurious_accept", 32'(bus.busy), 32'd0);

    // Reset while idx=1 during CALC
    start_op("t5", mk(15, 15, 15, 15, 15, 15), 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_rst_result", 32'(bus.result), 32'd0);
    check("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op("t5b", mk(2, 3, 1, 4, 0, 5), 1'b1);
    finish_op("t5b", 10, 0, 1'b0);

    // Operands scrambled while busy: the latched vector still gives 63
    start_op("t6", mk(7, 8, 2, 3, 1, 1), 1'b0);
    finish_op("t6", 63, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
